// File: rtl/ws2812_rx.sv
// WS2812 NRZ receiver: classifies high-pulse widths into bits and assembles 24-bit GRB words.
// Define WS2812_RX_FWD_EN to forward every bit after the first word on dout (daisy-chain pixel).
`timescale 1ns/1ps
module ws2812_rx #(
  parameter int T_MIN      = 4,
  parameter int T_THRESH   = 26,
  parameter int T_MAX_HIGH = 200,
  parameter int T_RESET    = 1250,
  parameter int IDX_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [23:0]      word_data,
  output logic             word_valid,
  output logic [IDX_W-1:0] word_idx,
  output logic             frame_end,
  output logic             err,
  output logic             dout
);

  typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH} state_t;

  localparam logic [16:0] MIN_L   = 17'(T_MIN);
  localparam logic [16:0] THR_L   = 17'(T_THRESH);
  localparam logic [16:0] MAXH_L  = 17'(T_MAX_HIGH);
  localparam logic [16:0] RESET_L = 17'(T_RESET);

  state_t           state_q, state_d;
  logic             din_m, din_s, din_d;
  logic             rise, fall;
  logic [15:0]      cnt;
  logic [16:0]      run;
  logic [23:0]      shift_q;
  logic [4:0]       bitcnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             bit_ok, bit_val, word_done, gap_hit, err_ev;

  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;
  // cnt is cleared in the edge cycle, so run equals the number of cycles din_s has held its level
  assign run  = {1'b0, cnt} + 17'd1;
  assign word_done = bit_ok && (bitcnt_q == 5'd23);

  always_comb begin
    state_d = state_q;
    bit_ok  = 1'b0;
    bit_val = 1'b0;
    gap_hit = 1'b0;
    err_ev  = 1'b0;
    case (state_q)
      WAIT_GAP: begin
        if (!din_s && run >= RESET_L) state_d = IDLE;
      end
      IDLE: begin
        if (rise)                 state_d = HIGH;
        else if (run == RESET_L)  gap_hit = 1'b1;
      end
      HIGH: begin
        if (fall) begin
          if (run < MIN_L) begin
            err_ev  = 1'b1;
            state_d = WAIT_GAP;
          end else begin
            bit_ok  = 1'b1;
            bit_val = (run >= THR_L);
            state_d = IDLE;
          end
        end else if (run == MAXH_L) begin
          err_ev  = 1'b1;
          state_d = WAIT_GAP;
        end
      end
      default: state_d = WAIT_GAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_GAP;
      din_m      <= 1'b0;
      din_s      <= 1'b0;
      din_d      <= 1'b0;
      cnt        <= '0;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      idx_q      <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      word_idx   <= '0;
      frame_end  <= 1'b0;
      err        <= 1'b0;
    end else begin
      din_m   <= din;
      din_s   <= din_m;
      din_d   <= din_s;
      state_q <= state_d;

      if (rise || fall || (state_q == WAIT_GAP && din_s)) cnt <= '0;
      else if (cnt != 16'hFFFF)                           cnt <= cnt + 16'd1;

      word_valid <= 1'b0;
      frame_end  <= 1'b0;
      err        <= err_ev | (gap_hit && bitcnt_q != 5'd0);

      if (bit_ok) begin
        shift_q  <= {shift_q[22:0], bit_val};
        bitcnt_q <= word_done ? 5'd0 : bitcnt_q + 5'd1;
      end
      if (word_done) begin
        word_data  <= {shift_q[22:0], bit_val};
        word_valid <= 1'b1;
        word_idx   <= idx_q;
        idx_q      <= idx_q + IDX_W'(1);
      end
      if (gap_hit) begin
        frame_end <= (idx_q != '0);
        idx_q     <= '0;
        bitcnt_q  <= '0;
      end
      // an aborted frame restarts from pixel 0 once the line has been idle for a full gap
      if (err_ev) begin
        idx_q    <= '0;
        bitcnt_q <= '0;
      end
    end
  end

`ifdef WS2812_RX_FWD_EN
  logic fwd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    fwd_q <= 1'b0;
    else if (gap_hit || err_ev) fwd_q <= 1'b0;
    else if (word_done)         fwd_q <= 1'b1;
  end

  assign dout = fwd_q & din_d;
`else
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: pulse-width stimulus, monitor queues, immediate-assert checks.
`timescale 1ns/1ps
module tb_ws2812_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic [23:0] word_data;
  logic        word_valid;
  logic [5:0]  word_idx;
  logic        frame_end;
  logic        err;
  logic        dout;

  ws2812_rx dut (
    .clk(clk), .rst(rst), .din(din),
    .word_data(word_data), .word_valid(word_valid), .word_idx(word_idx),
    .frame_end(frame_end), .err(err), .dout(dout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_word = 0, n_fe = 0, n_err = 0, n_dout = 0;
  int b_word, b_fe, b_err, b_dout;
  logic [23:0] wd[$];
  logic [5:0]  wi[$];
  int exp_dout;

  always @(negedge clk) begin
    if (word_valid) begin
      n_word++;
      wd.push_back(word_data);
      wi.push_back(word_idx);
    end
    if (frame_end) n_fe++;
    if (err)       n_err++;
    if (dout)      n_dout++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_d(input int k);
    if (k >= 0 && k < wd.size()) return {8'h0, wd[k]};
    return 'x;
  endfunction

  function automatic logic [31:0] get_i(input int k);
    if (k >= 0 && k < wi.size()) return {26'h0, wi[k]};
    return 'x;
  endfunction

  task automatic snap();
    b_word = n_word; b_fe = n_fe; b_err = n_err; b_dout = n_dout;
  endtask

  task automatic pulse(input int hi, input int lo);
    din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_bits(input logic [23:0] v, input int nbits, input int h1, input int l1,
                           input int h0, input int l0);
    for (int i = 23; i > 23 - nbits; i--) begin
      if (v[i]) pulse(h1, l1);
      else      pulse(h0, l0);
    end
  endtask

  task automatic send_word(input logic [23:0] v);
    send_bits(v, 24, 35, 29, 18, 39);
  endtask

  task automatic gap();
    din = 1'b0;
    repeat (1300) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_word_valid", {31'h0, word_valid}, 32'h0);
    chk("rst_word_data",  {8'h0, word_data},   32'h0);
    chk("rst_word_idx",   {26'h0, word_idx},   32'h0);
    chk("rst_frame_end",  {31'h0, frame_end},  32'h0);
    chk("rst_err",        {31'h0, err},        32'h0);
    chk("rst_dout",       {31'h0, dout},       32'h0);
    rst = 1'b0;
    gap();

    // single word
    snap();
    send_word(24'hA53C0F);
    gap();
    chk("w1_count", n_word - b_word, 1);
    chk("w1_data",  get_d(b_word), 32'hA53C0F);
    chk("w1_idx",   get_i(b_word), 0);
    chk("w1_fe",    n_fe - b_fe, 1);
    chk("w1_err",   n_err - b_err, 0);
    chk("w1_hold",  {8'h0, word_data}, 32'hA53C0F);

    // three words, then a second frame
    snap();
    send_word(24'hFF0000);
    send_word(24'h00FF00);
    send_word(24'h0000FF);
    gap();
    chk("w3_count", n_word - b_word, 3);
    chk("w3_d0", get_d(b_word),     32'hFF0000);
    chk("w3_i0", get_i(b_word),     0);
    chk("w3_d1", get_d(b_word + 1), 32'h00FF00);
    chk("w3_i1", get_i(b_word + 1), 1);
    chk("w3_d2", get_d(b_word + 2), 32'h0000FF);
    chk("w3_i2", get_i(b_word + 2), 2);
    chk("w3_fe", n_fe - b_fe, 1);
    send_word(24'h123456);
    gap();
    chk("f2_data", get_d(b_word + 3), 32'h123456);
    chk("f2_idx",  get_i(b_word + 3), 0);
    chk("f2_fe",   n_fe - b_fe, 2);

    // width boundaries: 26 -> 1, 25 -> 0, rest of 0x0000F0
    snap();
    pulse(26, 38);
    pulse(25, 38);
    send_bits(24'h0000F0 << 2, 22, 35, 29, 18, 39);
    gap();
    chk("bnd_data", get_d(b_word), 32'h8000F0);
    chk("bnd_err",  n_err - b_err, 0);

    // 3-cycle glitch: error, following word ignored until a gap
    snap();
    pulse(3, 40);
    send_word(24'h111111);
    gap();
    chk("gl_err",   n_err - b_err, 1);
    chk("gl_words", n_word - b_word, 0);
    chk("gl_fe",    n_fe - b_fe, 0);
    send_word(24'h222222);
    gap();
    chk("gl_resume_data", get_d(b_word), 32'h222222);
    chk("gl_resume_idx",  get_i(b_word), 0);

    // partial word (10 bits) then gap
    snap();
    send_bits(24'hABCDEF, 10, 35, 29, 18, 39);
    gap();
    chk("part_err",   n_err - b_err, 1);
    chk("part_fe",    n_fe - b_fe, 0);
    chk("part_words", n_word - b_word, 0);

    // stuck high
    snap();
    pulse(250, 10);
    send_word(24'h333333);
    gap();
    chk("stuck_err",   n_err - b_err, 1);
    chk("stuck_words", n_word - b_word, 0);

    // 65 short words in one frame: index wraps 63 -> 0
    snap();
    for (int k = 0; k < 65; k++) send_bits(24'(k), 24, 26, 4, 5, 5);
    gap();
    chk("wrap_count", n_word - b_word, 65);
    chk("wrap_i63",   get_i(b_word + 63), 63);
    chk("wrap_d63",   get_d(b_word + 63), 63);
    chk("wrap_i64",   get_i(b_word + 64), 0);
    chk("wrap_d64",   get_d(b_word + 64), 64);
    chk("wrap_fe",    n_fe - b_fe, 1);

    // reset mid-word
    snap();
    send_bits(24'hFFFFFF, 12, 35, 29, 18, 39);
    din = 1'b1;
    rst = 1'b1;
    #1;
    chk("mrst_data",  {8'h0, word_data},  32'h0);
    chk("mrst_valid", {31'h0, word_valid}, 32'h0);
    chk("mrst_idx",   {26'h0, word_idx},   32'h0);
    @(negedge clk);
    rst = 1'b0;
    din = 1'b0;
    repeat (30) @(negedge clk);
    send_bits(24'hFFFFFF, 12, 35, 29, 18, 39);
    send_word(24'h444444);
    gap();
    chk("mrst_nodecode", n_word - b_word, 0);
    send_word(24'hC0FFEE);
    gap();
    chk("mrst_resume_data", get_d(b_word), 32'hC0FFEE);
    chk("mrst_resume_idx",  get_i(b_word), 0);
    chk("mrst_err",         n_err - b_err, 0);

    // forwarding: only word 1 (4 ones x 35 + 20 zeros x 18 high cycles) reaches dout
    snap();
    send_word(24'h000000);
    send_word(24'hF00000);
    gap();
`ifdef WS2812_RX_FWD_EN
    exp_dout = 500;
`else
    exp_dout = 0;
`endif
    chk("fwd_dout_cycles", n_dout - b_dout, exp_dout);
    chk("fwd_words", n_word - b_word, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
